// File: rtl/cpu_types_pkg.sv
// Shared CPU type definitions: opcodes, function codes, ALU operations and
// the multicycle controller state encoding.
package cpu_types_pkg;

    typedef enum logic [5:0] {
        OP_RTYPE = 6'h00,
        OP_J     = 6'h02,
        OP_JAL   = 6'h03,
        OP_BEQ   = 6'h04,
        OP_BNE   = 6'h05,
        OP_ADDIU = 6'h09,
        OP_SLTI  = 6'h0A,
        OP_SLTIU = 6'h0B,
        OP_ANDI  = 6'h0C,
        OP_ORI   = 6'h0D,
        OP_XORI  = 6'h0E,
        OP_LUI   = 6'h0F,
        OP_LW    = 6'h23,
        OP_SW    = 6'h2B,
        OP_LL    = 6'h30,
        OP_SC    = 6'h38,
        OP_HALT  = 6'h3F
    } opcode_t;

    typedef enum logic [5:0] {
        FN_SLL  = 6'h00,
        FN_SRL  = 6'h02,
        FN_JR   = 6'h08,
        FN_ADD  = 6'h20,
        FN_ADDU = 6'h21,
        FN_SUB  = 6'h22,
        FN_SUBU = 6'h23,
        FN_AND  = 6'h24,
        FN_OR   = 6'h25,
        FN_XOR  = 6'h26,
        FN_NOR  = 6'h27,
        FN_SLT  = 6'h2A,
        FN_SLTU = 6'h2B
    } funct_t;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_NOR  = 4'd5,
        ALU_SLT  = 4'd6,
        ALU_SLTU = 4'd7,
        ALU_SLL  = 4'd8,
        ALU_SRL  = 4'd9
    } aluop_t;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        HALT   = 3'd5,
        ERROR  = 3'd6
    } mcstate_t;

endpackage

// File: rtl/alu_decode.sv
// Combinational opcode/funct to ALU operation decode; unknown encodings map to ADD.
module alu_decode
    import cpu_types_pkg::*;
(
    input  opcode_t i_opcode,
    input  funct_t  i_funct,
    output aluop_t  o_aluop
);

    always_comb begin
        o_aluop = ALU_ADD;
        case (i_opcode)
            OP_RTYPE: begin
                case (i_funct)
                    FN_SLL:          o_aluop = ALU_SLL;
                    FN_SRL:          o_aluop = ALU_SRL;
                    FN_ADD, FN_ADDU: o_aluop = ALU_ADD;
                    FN_SUB, FN_SUBU: o_aluop = ALU_SUB;
                    FN_AND:          o_aluop = ALU_AND;
                    FN_OR:           o_aluop = ALU_OR;
                    FN_XOR:          o_aluop = ALU_XOR;
                    FN_NOR:          o_aluop = ALU_NOR;
                    FN_SLT:          o_aluop = ALU_SLT;
                    FN_SLTU:         o_aluop = ALU_SLTU;
                    default:         o_aluop = ALU_ADD;
                endcase
            end
            OP_ADDIU, OP_LW, OP_SW, OP_LL, OP_SC: o_aluop = ALU_ADD;
            OP_ANDI:          o_aluop = ALU_AND;
            OP_ORI:           o_aluop = ALU_OR;
            OP_XORI:          o_aluop = ALU_XOR;
            OP_SLTI:          o_aluop = ALU_SLT;
            OP_SLTIU:         o_aluop = ALU_SLTU;
            OP_BEQ, OP_BNE:   o_aluop = ALU_SUB;
            default:          o_aluop = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle CPU controller: FETCH/DECODE/EXEC/MEM/WB with bus timeout.
// Define MCU_LLSC_EN to enable the LL/SC link register and link_inv.
module multicycle_control_unit
    import cpu_types_pkg::*;
#(
    parameter int unsigned TIMEOUT     = 255,
    parameter logic [31:0] SC_FAIL_VAL = 32'd0
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic [31:0] instr,
    input  logic        ihit,
    input  logic        dhit,
    input  logic        zero,
    input  logic        link_inv,
    output logic        iREN,
    output logic        dREN,
    output logic        dWEN,
    output logic        PCWr,
    output logic        RegWr,
    output logic        RegDst,
    output logic        ImmToAlu,
    output logic        ShamToAlu,
    output logic        ExtOp,
    output logic        ImmToReg,
    output logic        MemToReg,
    output logic        Jal,
    output logic        RegToPc,
    output aluop_t      aluop,
    output logic [31:0] scval,
    output mcstate_t    state,
    output logic        halt,
    output logic        bus_err
);

    localparam logic [15:0] LP_CNT_LAST = 16'(TIMEOUT - 1);

    mcstate_t    r_state;
    logic [31:0] r_ir;
    logic [15:0] r_cnt;
    logic        r_sc_ok;
    logic [31:0] r_scval;
    logic        r_halt;
    logic        r_bus_err;

    opcode_t w_op;
    funct_t  w_fn;
    aluop_t  w_aluop;
    logic    w_rtype, w_jr, w_shift, w_rtype_alu, w_imm_arith, w_lui;
    logic    w_load, w_mem, w_sext, w_wb_op, w_sc_grant, w_unused;

    assign w_op = opcode_t'(r_ir[31:26]);
    assign w_fn = funct_t'(r_ir[5:0]);

    assign w_rtype     = (w_op == OP_RTYPE);
    assign w_jr        = w_rtype && (w_fn == FN_JR);
    assign w_shift     = w_rtype && (w_fn == FN_SLL || w_fn == FN_SRL);
    assign w_rtype_alu = w_rtype && (w_fn inside {FN_SLL, FN_SRL, FN_ADD, FN_ADDU, FN_SUB, FN_SUBU,
                                                  FN_AND, FN_OR, FN_XOR, FN_NOR, FN_SLT, FN_SLTU});
    assign w_imm_arith = w_op inside {OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI};
    assign w_lui       = (w_op == OP_LUI);
    assign w_load      = (w_op == OP_LW) || (w_op == OP_LL);
    assign w_mem       = w_load || (w_op == OP_SW) || (w_op == OP_SC);
    assign w_sext      = w_mem || (w_op inside {OP_ADDIU, OP_SLTI, OP_SLTIU, OP_BEQ, OP_BNE});
    assign w_wb_op     = w_rtype_alu || w_imm_arith || w_lui;

`ifdef MCU_LLSC_EN
    logic r_link;
    assign w_sc_grant = r_link && !link_inv;
    assign w_unused   = ^r_ir[25:6];
`else
    assign w_sc_grant = 1'b1;
    assign w_unused   = ^{r_ir[25:6], link_inv};
`endif

    alu_decode u_alu_decode (
        .i_opcode (w_op),
        .i_funct  (w_fn),
        .o_aluop  (w_aluop)
    );

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state   <= FETCH;
            r_ir      <= '0;
            r_cnt     <= '0;
            r_sc_ok   <= 1'b0;
            r_scval   <= '0;
            r_halt    <= 1'b0;
            r_bus_err <= 1'b0;
`ifdef MCU_LLSC_EN
            r_link    <= 1'b0;
`endif
        end else begin
`ifdef MCU_LLSC_EN
            if (link_inv) r_link <= 1'b0;
`endif
            case (r_state)
                FETCH: begin
                    if (ihit) begin
                        r_ir    <= instr;
                        r_cnt   <= '0;
                        r_state <= DECODE;
                    end else if (r_cnt == LP_CNT_LAST) begin
                        r_state   <= ERROR;
                        r_halt    <= 1'b1;
                        r_bus_err <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                DECODE: begin
                    if (w_op == OP_HALT) begin
                        r_state <= HALT;
                        r_halt  <= 1'b1;
                    end else begin
                        r_state <= EXEC;
                    end
                end
                EXEC: begin
                    // SC success is decided once, from the link state at MEM entry
                    r_sc_ok <= w_sc_grant;
                    if (w_mem)        r_state <= MEM;
                    else if (w_wb_op) r_state <= WB;
                    else              r_state <= FETCH;
                end
                MEM: begin
                    if (w_op == OP_SC && !r_sc_ok) begin
                        r_state <= WB;
                        r_scval <= SC_FAIL_VAL;
                    end else if (dhit) begin
                        r_cnt   <= '0;
                        r_state <= (w_op == OP_SW) ? FETCH : WB;
                        if (w_op == OP_SC) begin
                            r_scval <= 32'd1;
`ifdef MCU_LLSC_EN
                            r_link  <= 1'b0;
`endif
                        end
`ifdef MCU_LLSC_EN
                        if (w_op == OP_LL) r_link <= !link_inv;
`endif
                    end else if (r_cnt == LP_CNT_LAST) begin
                        r_state   <= ERROR;
                        r_halt    <= 1'b1;
                        r_bus_err <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                WB:      r_state <= FETCH;
                default: r_state <= r_state;
            endcase
        end
    end

    // Strobes are gated by nRST so they drop the instant reset asserts.
    always_comb begin
        iREN      = 1'b0;
        dREN      = 1'b0;
        dWEN      = 1'b0;
        PCWr      = 1'b0;
        RegWr     = 1'b0;
        RegDst    = 1'b0;
        ImmToAlu  = 1'b0;
        ShamToAlu = 1'b0;
        ExtOp     = 1'b0;
        ImmToReg  = 1'b0;
        MemToReg  = 1'b0;
        Jal       = 1'b0;
        RegToPc   = 1'b0;
        aluop     = ALU_ADD;
        if (nRST) begin
            case (r_state)
                FETCH: begin
                    iREN = 1'b1;
                    PCWr = ihit;
                end
                EXEC: begin
                    aluop     = w_aluop;
                    ImmToAlu  = w_imm_arith || w_mem;
                    ShamToAlu = w_shift;
                    ExtOp     = w_sext;
                    RegToPc   = w_jr;
                    PCWr      = (w_op == OP_BEQ && zero) || (w_op == OP_BNE && !zero) ||
                                (w_op == OP_J) || (w_op == OP_JAL) || w_jr;
                    RegWr     = (w_op == OP_JAL);
                    Jal       = (w_op == OP_JAL);
                end
                MEM: begin
                    dREN = w_load;
                    dWEN = (w_op == OP_SW) || (w_op == OP_SC && r_sc_ok);
                end
                WB: begin
                    RegWr    = 1'b1;
                    RegDst   = w_rtype;
                    MemToReg = w_load;
                    ImmToReg = w_lui;
                end
                default: ;
            endcase
        end
    end

    assign state   = r_state;
    assign scval   = r_scval;
    assign halt    = r_halt;
    assign bus_err = r_bus_err;

endmodule

// File: doc/multicycle_control_unit.md
MULTICYCLE_CONTROL_UNIT -- requirements
Module: multicycle_control_unit

Interface
REQ-001 Parameter TIMEOUT, default 255: max wait cycles for ihit/dhit before bus error; legal range 1..65535.
REQ-002 Parameter SC_FAIL_VAL, default 0: value placed on scval when SC fails; success value is always 1.
REQ-003 CLK  in  1  single clock; all state updates on rising edge.
REQ-004 nRST  in  1  reset, asynchronous, active-low.
REQ-005 instr  in  32  instruction word from memory, captured into internal IR on fetch.
REQ-006 ihit / dhit  in  1 each  instruction / data memory completion strobes.
REQ-007 zero  in  1  ALU zero flag, sampled in EXEC for branches.
REQ-008 link_inv  in  1  coherence invalidate of the LL link (1-cycle pulse).
REQ-009 iREN, dREN, dWEN  out  1 each  memory request strobes.
REQ-010 PCWr, RegWr, RegDst, ImmToAlu, ShamToAlu, ExtOp, ImmToReg, MemToReg, Jal, RegToPc  out  1 each  datapath controls.
REQ-011 aluop  out  aluop_t  ALU operation; scval out 32 SC result; state out mcstate_t; halt out 1; bus_err out 1.

Function
REQ-012 States: FETCH, DECODE, EXEC, MEM, WB, HALT, ERROR; reset state FETCH.
REQ-013 FETCH: iREN=1 every cycle; on ihit, IR<=instr, PCWr=1 (PC+4) that cycle, next DECODE.
REQ-014 DECODE: exactly 1 cycle, no strobes; control outputs derived from IR opcode/funct; HALT opcode -> HALT.
REQ-015 EXEC: aluop valid; BEQ/BNE assert PCWr iff zero==1 / zero==0, J/JAL/JR assert PCWr, then FETCH; JAL also RegWr, Jal=1 same cycle.
REQ-016 EXEC of LW/SW/LL/SC -> MEM; all other register-writing ops -> WB.
REQ-017 MEM: dREN (LW/LL) or dWEN (SW, SC with link valid) held until dhit, then WB (loads/LL/SC) or FETCH (SW).
REQ-018 SC with link invalid on MEM entry: no dWEN, advance to WB next cycle, scval=SC_FAIL_VAL; successful SC: scval=1, link cleared.
REQ-019 WB: RegWr=1 for exactly 1 cycle, MemToReg=1 for loads, then FETCH.
REQ-020 Wait counter: cleared on entry to FETCH/MEM, increments each non-hit cycle; reaching TIMEOUT without hit -> ERROR; hit in the TIMEOUT cycle wins.
REQ-021 ERROR: bus_err=1, halt=1, no strobes, sticky until reset; HALT: halt=1, no strobes, sticky until reset.
REQ-022 aluop mapping: R-type funct SLL/SRL/ADD(U)/SUB(U)/AND/OR/XOR/NOR/SLT/SLTU to matching ALU op; ADDIU/LW/SW/LL/SC ADD, ANDI AND, ORI OR, XORI XOR, SLTI SLT, SLTIU SLTU, BEQ/BNE SUB; undefined -> ADD.
REQ-023 All datapath controls 0 outside the state that uses them; no strobe asserted in more than one state per instruction.

Reset
REQ-024 nRST low: state=FETCH, IR=0, counter=0, link=0, bus_err=0, halt=0, all strobes/controls 0, immediately and without clock.
REQ-025 Reset mid-MEM aborts the access; first post-reset cycle asserts iREN.

Configuration
REQ-026 Macro MCU_LLSC_EN: defined -> link register, link_inv and REQ-018 active; LL sets link on dhit unless link_inv same cycle (invalidate wins).
REQ-027 MCU_LLSC_EN undefined -> LL behaves as LW, SC as SW with scval=1, link_inv ignored.

Structure
REQ-028 mcstate_t added to cpu_types_pkg alongside opcode_t, funct_t, aluop_t; no local duplicates.
REQ-029 One sub-module alu_decode: combinational opcode/funct -> aluop per REQ-022.

Verification
REQ-030 ADDU after ihit delayed 3 cycles -> FETCH(4)/DECODE/EXEC/WB, RegWr high 1 cycle, aluop=ALU_ADD.
REQ-031 BEQ with zero=1 -> PCWr in FETCH and EXEC; zero=0 -> PCWr only in FETCH.
REQ-032 TIMEOUT=4, dhit never arrives on LW -> ERROR after 4 MEM cycles, bus_err=1, stays until nRST.
REQ-033 LL, link_inv pulse, SC -> no dWEN, scval=0; LL, SC without invalidate -> dWEN, scval=1.
REQ-034 nRST asserted mid-MEM of SW -> dWEN drops asynchronously, state=FETCH, iREN next cycle after release.
REQ-035 HALT opcode 0x3F -> halt=1 after DECODE, no further iREN for 20 cycles.
